// File: rtl/mini_mips_cpu.sv
// Single-cycle, word-addressed MIPS-like core with internal instruction and data memories.
// While rst is high the PC and both register files clear and the load port fills the memories.
module mini_mips_cpu #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_data,
  input  logic [9:0]  address,
  input  logic        write_instruction,
  input  logic        write_data,
  output logic [31:0] OutputOfRs
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_BGE   = 6'b010101;
  localparam logic [5:0] OP_MTC1  = 6'b011000;
  localparam logic [5:0] OP_MFC1  = 6'b011001;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] gpr  [32];
  logic [31:0] fpr  [32];
  logic [9:0]  pc;

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rt, rs, rd;
  logic [31:0] imm_sx, rs_val, rt_val, ea, gpr_wdata;
  logic [9:0]  pc_inc, branch_tgt, pc_next, daddr;
  logic [4:0]  gpr_waddr;
  logic        gpr_we, fpr_we, dmem_we;
  logic        unused_bits;

  assign instr  = imem[pc];
  assign op     = instr[31:26];
  assign rt     = instr[25:21];
  assign rs     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm_sx = {{16{instr[15]}}, instr[15:0]};

  assign rs_val     = (rs == 5'd0) ? 32'd0 : gpr[rs];
  assign rt_val     = (rt == 5'd0) ? 32'd0 : gpr[rt];
  assign OutputOfRs = rs_val;

  // Only the low 10 bits of the effective address reach the word-indexed memory.
  assign ea          = rs_val + imm_sx;
  assign daddr       = ea[9:0];
  assign pc_inc      = pc + 10'd1;
  assign branch_tgt  = pc_inc + imm_sx[9:0];
  assign unused_bits = ^{instr[10:6], ea[31:10]};

  always_comb begin
    gpr_we    = 1'b0;
    gpr_waddr = rt;
    gpr_wdata = 32'd0;
    fpr_we    = 1'b0;
    dmem_we   = 1'b0;
    pc_next   = pc_inc;
    case (op)
      OP_RTYPE: begin
        gpr_waddr = rd;
        gpr_we    = 1'b1;
        case (funct)
          FN_ADD:  gpr_wdata = rs_val + rt_val;
          FN_SUB:  gpr_wdata = rs_val - rt_val;
          FN_AND:  gpr_wdata = rs_val & rt_val;
          FN_OR:   gpr_wdata = rs_val | rt_val;
          FN_XOR:  gpr_wdata = rs_val ^ rt_val;
          FN_SLT:  gpr_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
          default: gpr_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        gpr_we    = 1'b1;
        gpr_wdata = ea;
      end
      OP_LW: begin
        gpr_we    = 1'b1;
        gpr_wdata = dmem[daddr];
      end
      OP_SW:   dmem_we = 1'b1;
      OP_BEQ:  if (rt_val == rs_val) pc_next = branch_tgt;
      OP_BNE:  if (rt_val != rs_val) pc_next = branch_tgt;
      OP_BGE:  if ($signed(rt_val) >= $signed(rs_val)) pc_next = branch_tgt;
      OP_MTC1: fpr_we = 1'b1;
      OP_MFC1: begin
        gpr_we    = 1'b1;
        gpr_wdata = fpr[rs];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 10'd0;
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= 32'd0;
        fpr[i] <= 32'd0;
      end
      if (write_instruction) imem[address] <= inst_data;
      if (write_data)        dmem[address] <= inst_data;
    end else begin
      pc <= pc_next;
      if (gpr_we && (gpr_waddr != 5'd0)) gpr[gpr_waddr] <= gpr_wdata;
      if (fpr_we)  fpr[rt]     <= rs_val;
      if (dmem_we) dmem[daddr] <= rt_val;
    end
  end
endmodule

// File: tb/tb_mini_mips_cpu.sv
// Directed bench for mini_mips_cpu: load port, ALU/branch/memory/FPR program, mid-run reset, insertion sort.
module tb_mini_mips_cpu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_data;
  logic [9:0]  address;
  logic        write_instruction;
  logic        write_data;
  logic [31:0] OutputOfRs;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] ADDI = 6'b000001, LW = 6'b000111, SW = 6'b001000;
  localparam logic [5:0] BEQ = 6'b010000, BNE = 6'b010001, BGE = 6'b010101;
  localparam logic [5:0] MTC1 = 6'b011000, MFC1 = 6'b011001;

  mini_mips_cpu dut (
    .clk               (clk),
    .rst               (rst),
    .inst_data         (inst_data),
    .address           (address),
    .write_instruction (write_instruction),
    .write_data        (write_data),
    .OutputOfRs        (OutputOfRs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rt, rs, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'b000000, rt, rs, rd, 5'b00000, fn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d, input logic wi, input logic wd);
    address = a; inst_data = d; write_instruction = wi; write_data = wd;
    step();
    write_instruction = 1'b0; write_data = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] prog_a [22];
  logic [31:0] prog_s [15];
  logic [31:0] sorted [5];
  logic [31:0] init_d [5];

  initial begin
    rst = 1'b1; inst_data = '0; address = '0; write_instruction = 1'b0; write_data = 1'b0;
    init_d = '{32'd7, 32'd12, 32'd9, 32'd11, 32'd3};
    sorted = '{32'd3, 32'd7, 32'd9, 32'd11, 32'd12};

    prog_a[0]  = itype(ADDI, 5'd1, 5'd0, 16'd5);
    prog_a[1]  = itype(ADDI, 5'd2, 5'd1, 16'hFFFF);
    prog_a[2]  = itype(ADDI, 5'd0, 5'd0, 16'd9);
    prog_a[3]  = rtype(5'd3, 5'd2, 5'd1, 6'b100000);
    prog_a[4]  = rtype(5'd4, 5'd1, 5'd2, 6'b100010);
    prog_a[5]  = rtype(5'd5, 5'd1, 5'd2, 6'b100100);
    prog_a[6]  = rtype(5'd6, 5'd1, 5'd2, 6'b100101);
    prog_a[7]  = rtype(5'd7, 5'd1, 5'd2, 6'b100110);
    prog_a[8]  = rtype(5'd8, 5'd2, 5'd1, 6'b101010);
    prog_a[9]  = itype(BNE, 5'd1, 5'd1, 16'd5);
    prog_a[10] = itype(BGE, 5'd1, 5'd2, 16'd2);
    prog_a[11] = itype(ADDI, 5'd9, 5'd0, 16'd99);
    prog_a[12] = itype(ADDI, 5'd9, 5'd0, 16'd99);
    prog_a[13] = itype(SW, 5'd1, 5'd2, 16'd20);
    prog_a[14] = itype(LW, 5'd10, 5'd2, 16'd20);
    prog_a[15] = itype(ADDI, 5'd11, 5'd0, 16'hFFFE);
    prog_a[16] = itype(MTC1, 5'd3, 5'd11, 16'd0);
    prog_a[17] = itype(MFC1, 5'd12, 5'd3, 16'd0);
    prog_a[18] = rtype(5'd13, 5'd11, 5'd1, 6'b101010);
    prog_a[19] = 32'hFC21FFFF;
    prog_a[20] = rtype(5'd14, 5'd1, 5'd1, 6'b000001);
    prog_a[21] = itype(BEQ, 5'd0, 5'd0, 16'd1000);

    prog_s[0]  = itype(ADDI, 5'd1,  5'd0, 16'd0);
    prog_s[1]  = itype(ADDI, 5'd31, 5'd0, 16'd5);
    prog_s[2]  = itype(ADDI, 5'd1,  5'd0, 16'd0);
    prog_s[3]  = itype(ADDI, 5'd1,  5'd1, 16'd1);
    prog_s[4]  = itype(BEQ,  5'd31, 5'd1, 16'd256);
    prog_s[5]  = itype(ADDI, 5'd2,  5'd1, 16'hFFFF);
    prog_s[6]  = itype(ADDI, 5'd5,  5'd2, 16'd1);
    prog_s[7]  = itype(LW,   5'd7,  5'd2, 16'd0);
    prog_s[8]  = itype(LW,   5'd8,  5'd5, 16'd0);
    prog_s[9]  = itype(BGE,  5'd8,  5'd7, 16'hFFF9);
    prog_s[10] = itype(SW,   5'd7,  5'd5, 16'd0);
    prog_s[11] = itype(SW,   5'd8,  5'd2, 16'd0);
    prog_s[12] = itype(BEQ,  5'd2,  5'd0, 16'hFFF6);
    prog_s[13] = itype(ADDI, 5'd2,  5'd2, 16'hFFFF);
    prog_s[14] = itype(BEQ,  5'd0,  5'd0, 16'hFFF7);

    step();
    for (int i = 0; i < 1024; i++) load(10'(i), 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) load(10'(i), init_d[i], 1'b0, 1'b1);
    load(10'd500, 32'hABCD1234, 1'b1, 1'b1);
    chk("both_flags_imem", dut.imem[500], 32'hABCD1234);
    chk("both_flags_dmem", dut.dmem[500], 32'hABCD1234);
    for (int i = 0; i < 22; i++) load(10'(i), prog_a[i], 1'b1, 1'b0);
    chk("reset_hold_pc", {22'd0, dut.pc}, 32'd0);
    chk("reset_hold_gpr1", dut.gpr[1], 32'd0);
    for (int i = 0; i < 5; i++) chk($sformatf("load_dmem%0d", i), dut.dmem[i], init_d[i]);

    // Run program A with the load port driven; it must be ignored outside reset.
    rst = 1'b0;
    address = 10'd30; inst_data = 32'hDEAD0000; write_data = 1'b1; write_instruction = 1'b1;
    chk("rs_out_pc0", OutputOfRs, 32'd0);
    step();
    chk("pc_inc1", {22'd0, dut.pc}, 32'd1);
    chk("addi_1", dut.gpr[1], 32'd5);
    chk("rs_out_pc1", OutputOfRs, 32'd5);
    step();
    chk("pc_inc2", {22'd0, dut.pc}, 32'd2);
    chk("addi_neg", dut.gpr[2], 32'd4);
    step();
    chk("zero_reg", dut.gpr[0], 32'd0);
    chk("rs_out_pc3", OutputOfRs, 32'd4);
    for (int i = 0; i < 6; i++) step();
    chk("add", dut.gpr[3], 32'd9);
    chk("sub", dut.gpr[4], 32'd1);
    chk("and", dut.gpr[5], 32'd4);
    chk("or",  dut.gpr[6], 32'd5);
    chk("xor", dut.gpr[7], 32'd1);
    chk("slt", dut.gpr[8], 32'd1);
    chk("pc_9", {22'd0, dut.pc}, 32'd9);
    step();
    chk("bne_untaken", {22'd0, dut.pc}, 32'd10);
    step();
    chk("bge_taken", {22'd0, dut.pc}, 32'd13);
    step();
    chk("sw", dut.dmem[24], 32'd5);
    step();
    chk("lw", dut.gpr[10], 32'd5);
    chk("skipped", dut.gpr[9], 32'd0);
    step();
    chk("rs_out_pc16", OutputOfRs, 32'hFFFFFFFE);
    step();
    chk("mtc1", dut.fpr[3], 32'hFFFFFFFE);
    step();
    chk("mfc1", dut.gpr[12], 32'hFFFFFFFE);
    step();
    chk("slt_signed", dut.gpr[13], 32'd1);
    step();
    chk("undef_op_pc", {22'd0, dut.pc}, 32'd20);
    chk("undef_op_gpr1", dut.gpr[1], 32'd5);
    step();
    chk("bad_funct", dut.gpr[14], 32'd0);
    chk("bad_funct_pc", {22'd0, dut.pc}, 32'd21);
    step();
    chk("beq_far", {22'd0, dut.pc}, 32'd1022);
    step();
    step();
    chk("pc_wrap", {22'd0, dut.pc}, 32'd0);
    chk("load_ignored_dmem", dut.dmem[30], 32'd0);
    chk("load_ignored_imem", dut.imem[30], 32'd0);
    write_data = 1'b0; write_instruction = 1'b0;
    step();
    step();

    rst = 1'b1;
    step();
    chk("midrst_pc", {22'd0, dut.pc}, 32'd0);
    chk("midrst_gpr12", dut.gpr[12], 32'd0);
    chk("midrst_gpr1", dut.gpr[1], 32'd0);
    chk("midrst_fpr3", dut.fpr[3], 32'd0);
    chk("midrst_mem_kept", dut.dmem[24], 32'd5);

    for (int i = 0; i < 15; i++) load(10'(i), prog_s[i], 1'b1, 1'b0);
    for (int i = 15; i < 22; i++) load(10'(i), 32'd0, 1'b1, 1'b0);
    chk("sort_hold_pc", {22'd0, dut.pc}, 32'd0);

    rst = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (i == 10) chk("bge_back_to_3", {22'd0, dut.pc}, 32'd3);
      if (i == 17) chk("bge_untaken", {22'd0, dut.pc}, 32'd10);
      if (i == 21) chk("pc_at_14", {22'd0, dut.pc}, 32'd14);
      if (i == 22) chk("beq_back_to_6", {22'd0, dut.pc}, 32'd6);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("sorted%0d", i), dut.dmem[i], sorted[i]);
    chk("sort_r31", dut.gpr[31], 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
